// File: rtl/shift_reg_seq.sv
// shift_reg_seq: multicycle shift register unit. Performs LOAD and
// logical/arithmetic/rotate shifts one bit position per clock, and hands
// completion back to the control FSM with a busy/done handshake.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - command strobe, sampled only in IDLE
//   op       - 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL,
//              110 ROR, 111 reserved (NOP)
//   shamt    - shift count, sampled with start
//   data_in  - operand captured by LOAD
//   data_out - shift register contents (registered)
//   busy     - high while a shift is in progress (registered)
//   done     - one-cycle completion pulse (registered)
module shift_reg_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [NBITS-1:0] shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b010;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SRA  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b101;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic [WIDTH-1:0]  step;
    logic [NBITS-1:0]  count, count_nxt;
    logic [OP_W-1:0]   op_q, op_nxt;

    // State and datapath registers; busy/done are decoded from the next state
    // so they are flops that mirror the state register exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            data_out <= '0;
            count    <= '0;
            op_q     <= OP_NOP;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_out <= data_nxt;
            count    <= count_nxt;
            op_q     <= op_nxt;
            busy     <= (state_nxt == SHIFT);
            done     <= (state_nxt == DONE);
        end
    end

    // Single-bit step for the latched operation.
    always_comb begin
        step = data_out;
        case (op_q)
            OP_SLL:  step = {data_out[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, data_out[WIDTH-1:1]};
            OP_SRA:  step = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            OP_ROL:  step = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            OP_ROR:  step = {data_out[0], data_out[WIDTH-1:1]};
            default: step = data_out;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        count_nxt = count;
        op_nxt    = op_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DONE;
                    case (op)
                        OP_LOAD: data_nxt = data_in;
                        OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                            // Zero count completes immediately with no data change.
                            if (shamt != '0) begin
                                state_nxt = SHIFT;
                                op_nxt    = op;
                                count_nxt = shamt;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                data_nxt  = step;
                count_nxt = count - NBITS'(1);
                if (count == NBITS'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed, table-driven bench for shift_reg_seq plus
// hand-written sequences for reset-abort and ignored-start corner cases.
module tb_shift_reg_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NBITS = 5;
    localparam int          MAX_WAIT = 100;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [NBITS-1:0] shamt;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]       op;
        logic [NBITS-1:0] shamt;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_data;
        int               exp_busy;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    shift_reg_seq #(.WIDTH(WIDTH), .NBITS(NBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command and observe the handshake at negedges after the accept edge.
    task automatic run_cmd(input logic [2:0] c_op, input logic [NBITS-1:0] c_sh,
                           input logic [WIDTH-1:0] c_din,
                           output int busy_cnt, output int done_cnt, output int done_lat);
        busy_cnt = 0;
        done_cnt = 0;
        done_lat = -1;
        @(negedge clk);
        start   = 1'b1;
        op      = c_op;
        shamt   = c_sh;
        data_in = c_din;
        @(negedge clk);
        start   = 1'b0;
        op      = OP_NOP;
        data_in = 32'hDEAD_BEEF;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_lat = k;
                break;
            end
            @(negedge clk);
        end
        // Cycle after done: back in IDLE, no second pulse.
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    initial begin
        int bc, dc, dl;
        logic [WIDTH-1:0] held;
        int seen_done, seen_busy, first_done_k;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{OP_LOAD, 5'd0,  32'h0000_ABCD, 32'h0000_ABCD, 0};
        vecs[1]  = '{OP_SLL,  5'd16, 32'h1111_1111, 32'hABCD_0000, 16};
        vecs[2]  = '{OP_LOAD, 5'd3,  32'h8000_0001, 32'h8000_0001, 0};
        vecs[3]  = '{OP_SRA,  5'd4,  32'h0,         32'hF800_0000, 4};
        vecs[4]  = '{OP_LOAD, 5'd0,  32'h8000_0001, 32'h8000_0001, 0};
        vecs[5]  = '{OP_SRL,  5'd4,  32'h0,         32'h0800_0000, 4};
        vecs[6]  = '{OP_LOAD, 5'd0,  32'h8000_0001, 32'h8000_0001, 0};
        vecs[7]  = '{OP_ROL,  5'd1,  32'h0,         32'h0000_0003, 1};
        vecs[8]  = '{OP_ROR,  5'd1,  32'h0,         32'h8000_0001, 1};
        vecs[9]  = '{OP_LOAD, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        vecs[10] = '{OP_SRL,  5'd31, 32'h0,         32'h0000_0001, 31};
        vecs[11] = '{OP_SLL,  5'd0,  32'hFFFF_0000, 32'h0000_0001, 0};
        vecs[12] = '{OP_NOP,  5'd7,  32'h5555_5555, 32'h0000_0001, 0};
        vecs[13] = '{OP_RSV,  5'd7,  32'h5555_5555, 32'h0000_0001, 0};
        vecs[14] = '{OP_ROR,  5'd31, 32'h0,         32'h0000_0002, 31};
        vecs[15] = '{OP_LOAD, 5'd0,  32'h1234_5678, 32'h1234_5678, 0};
        vecs[16] = '{OP_ROL,  5'd4,  32'h0,         32'h2345_6781, 4};
        vecs[17] = '{OP_SRA,  5'd8,  32'h0,         32'h0023_4567, 8};
        vecs[18] = '{OP_SLL,  5'd1,  32'h0,         32'h0046_8ACE, 1};
        vecs[19] = '{OP_ROR,  5'd0,  32'h0,         32'h0046_8ACE, 0};

        start   = 1'b0;
        op      = OP_NOP;
        shamt   = '0;
        data_in = '0;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", data_out, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_release_busy", 32'(busy), 32'h0);

        // Table-driven commands.
        for (int i = 0; i < NVEC; i++) begin
            run_cmd(vecs[i].op, vecs[i].shamt, vecs[i].din, bc, dc, dl);
            check($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d_done_pulses", i), 32'(dc), 32'd1);
            check($sformatf("v%0d_done_latency", i), 32'(dl), 32'(vecs[i].exp_busy + 1));
        end

        // Idle hold: data_out stable with start low.
        held = data_out;
        repeat (5) @(negedge clk);
        check("idle_hold", data_out, held);

        // Reset mid-shift aborts with no done pulse.
        run_cmd(OP_LOAD, 5'd0, 32'h0000_ABCD, bc, dc, dl);
        @(negedge clk);
        start = 1'b1; op = OP_SLL; shamt = 5'd16;
        @(negedge clk);
        start = 1'b0; op = OP_NOP;
        seen_done = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("midshift_busy_before_reset", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("midshift_reset_data", data_out, 32'h0);
        check("midshift_reset_busy", 32'(busy), 32'h0);
        check("midshift_reset_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_busy = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check("midshift_no_done", 32'(seen_done), 32'h0);
        check("midshift_idle_busy", 32'(seen_busy), 32'h0);
        check("midshift_idle_data", data_out, 32'h0);

        // Start during SHIFT and during DONE is ignored.
        run_cmd(OP_LOAD, 5'd0, 32'hFF00_0000, bc, dc, dl);
        @(negedge clk);
        start = 1'b1; op = OP_SRL; shamt = 5'd8;
        @(negedge clk);
        start = 1'b0; op = OP_NOP;
        seen_done = 0;
        seen_busy = 0;
        first_done_k = -1;
        for (int k = 1; k <= 30; k++) begin
            if (busy) seen_busy++;
            if (done) begin
                seen_done++;
                if (first_done_k < 0) first_done_k = k;
            end
            if (k == 3 || (done && first_done_k == k)) begin
                start = 1'b1; op = OP_LOAD; data_in = 32'h1234_5678; shamt = 5'd3;
            end else begin
                start = 1'b0; op = OP_NOP;
            end
            @(negedge clk);
        end
        check("ignore_data", data_out, 32'h00FF_0000);
        check("ignore_busy_cycles", 32'(seen_busy), 32'd8);
        check("ignore_done_pulses", 32'(seen_done), 32'd1);
        check("ignore_done_latency", 32'(first_done_k), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Multicycle shift register unit that consumes the 5-bit shift amount chosen by the shift-amount select mux in the datapath.
- Holds a WIDTH-bit operand and performs logical, arithmetic and rotate shifts, one bit position per clock.
- Signals completion to the control FSM with a `busy`/`done` handshake.
- Sits between the shift-amount/source muxes and the register-file write-back mux.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NBITS, 5, width of shamt; maximum shift is 2^NBITS-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  command strobe; sampled only in IDLE.
- op  input  3  command: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 reserved (treated as NOP).
- shamt  input  NBITS  shift count, sampled with start.
- data_in  input  WIDTH  operand, captured by LOAD.
- data_out  output  WIDTH  internal shift register contents, registered.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, data_out = 0, count = 0.
  - busy = 0, done = 0, latched op = NOP.
  - Reset asserted mid-shift aborts the operation; no done pulse is produced.
- States are IDLE, SHIFT and DONE. busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE, edge with start=1:
  - LOAD: data_out <= data_in; next state DONE.
  - NOP/reserved: no data change; next state DONE.
  - Shift op with shamt==0: no data change; next state DONE.
  - Shift op with shamt!=0: latch op, count <= shamt; next state SHIFT.
  - start=0: remain IDLE and hold data_out.
- SHIFT, each edge: apply one single-bit step per the latched op, then count <= count-1. When count==1 before the edge, the edge performs the final step and next state is DONE.
  - SLL: {d[W-2:0],0}.
  - SRL: {0,d[W-1:1]}.
  - SRA: {d[W-1],d[W-1:1]}.
  - ROL: {d[W-2:0],d[W-1]}.
  - ROR: {d[0],d[W-1:1]}.
- DONE: done=1 for exactly one cycle, data_out is final; next state IDLE unconditionally.
- Latency, with accept edge = E0:
  - Shift by N>0: shift edges E1..EN; busy high after E0 through EN; done high in the cycle after EN; IDLE after EN+1.
  - LOAD, NOP or N=0: done high in the cycle after E0.
- start during SHIFT or DONE is ignored; the command is not queued. op, shamt and data_in changes during SHIFT have no effect.
- data_out is held stable in IDLE and DONE; it changes only on LOAD or SHIFT edges.
- Width rules:
  - Count is NBITS wide.
  - shamt = 2^NBITS-1 (31) is legal and takes 31 shift cycles.
  - Shifts of WIDTH or more are unreachable with the default parameters.
- The datapath's default shamt of 16 (LUI path) is just another legal count: no special casing.

Test Plan:
- Reset released, then reset pulled low mid-shift (LOAD 0x0000ABCD, SLL shamt=16, reset at shift cycle 5) -> data_out=0, busy=0, done never pulses; IDLE after release.
- LOAD 0x0000ABCD, then SLL shamt=16 -> busy high 16 cycles, done pulses once, data_out=0xABCD0000.
- LOAD 0x80000001, SRA shamt=4 -> data_out=0xF8000000 after 4 shift cycles. Repeat with SRL shamt=4 -> 0x08000000.
- LOAD 0x80000001, ROL shamt=1 -> 0x00000003. Then ROR shamt=1 -> 0x80000001 restored.
- LOAD 0xFFFFFFFF, SRL shamt=31 -> 31 busy cycles, data_out=0x00000001. Then SLL shamt=0 -> done the cycle after accept, busy never high, data_out unchanged.
- During an SRL shamt=8 on 0xFF000000: pulse start with LOAD 0x12345678 mid-shift, and again in the DONE cycle -> both ignored, data_out=0x00FF0000, exactly one done pulse.
